// File: rtl/sram_1rw_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_1rw_arbiter
// Description : Two-requester arbiter in front of a single-port (1RW) SRAM.
//               Round-robin by default; define SRAM_ARB_FIXED_PRIORITY_EN
//               to give p0 fixed priority instead.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_1rw_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  p0_valid,
    output logic                  p0_ready,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    input  logic [DATA_WIDTH-1:0] p0_wmask,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,

    input  logic                  p1_valid,
    output logic                  p1_ready,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    input  logic [DATA_WIDTH-1:0] p1_wmask,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,

    output logic                  a_re,
    output logic                  a_we,
    output logic [ADDR_WIDTH-1:0] a_addr,
    output logic [DATA_WIDTH-1:0] a_data_in,
    output logic [DATA_WIDTH-1:0] a_wmask,
    input  logic [DATA_WIDTH-1:0] a_data_out
);

    logic                  w_grant0;
    logic                  w_grant1;
    logic                  w_any;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic [DATA_WIDTH-1:0] w_sel_wmask;

    logic                  r_rd_valid;
    logic                  r_rd_tag;

`ifdef SRAM_ARB_FIXED_PRIORITY_EN
    assign w_grant0 = ~rst & p0_valid;
    assign w_grant1 = ~rst & p1_valid & ~p0_valid;
`else
    // r_last_grant = 1 means p1 was granted most recently, so p0 wins next.
    logic r_last_grant;

    assign w_grant0 = ~rst & p0_valid & (~p1_valid | r_last_grant);
    assign w_grant1 = ~rst & p1_valid & (~p0_valid | ~r_last_grant);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (w_any) begin
            r_last_grant <= w_grant1;
        end
    end
`endif

    assign w_any    = w_grant0 | w_grant1;
    assign p0_ready = w_grant0;
    assign p1_ready = w_grant1;

    assign w_sel_we    = w_grant1 ? p1_we    : p0_we;
    assign w_sel_addr  = w_grant1 ? p1_addr  : p0_addr;
    assign w_sel_wdata = w_grant1 ? p1_wdata : p0_wdata;
    assign w_sel_wmask = w_grant1 ? p1_wmask : p0_wmask;

    always_comb begin
        a_re      = 1'b0;
        a_we      = 1'b0;
        a_addr    = '0;
        a_data_in = '0;
        a_wmask   = '0;
        if (w_any) begin
            a_addr = w_sel_addr;
            if (w_sel_we) begin
                a_we      = 1'b1;
                a_data_in = w_sel_wdata;
                a_wmask   = w_sel_wmask;
            end else begin
                a_re = 1'b1;
            end
        end
    end

    // Response owner: valid flag plus 1-bit requester tag for the read in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_tag   <= 1'b0;
        end else begin
            r_rd_valid <= w_any & ~w_sel_we;
            r_rd_tag   <= w_grant1;
        end
    end

    assign p0_rvalid = r_rd_valid & ~r_rd_tag;
    assign p1_rvalid = r_rd_valid &  r_rd_tag;
    assign p0_rdata  = p0_rvalid ? a_data_out : '0;
    assign p1_rdata  = p1_rvalid ? a_data_out : '0;

endmodule
`default_nettype wire

// File: doc/sram_1rw_arbiter.md
SRAM_1RW_ARBITER -- requirements
Module: sram_1rw_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, SRAM word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 32, SRAM word count; ADDR_WIDTH = $clog2(DEPTH), default 5.
REQ-003 The block SHALL have one clock; reset SHALL be asynchronous and active-high.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 p0_valid / p1_valid  input  1  requester n presents an operation.
REQ-007 p0_ready / p1_ready  output  1  requester n operation accepted this cycle.
REQ-008 p0_we / p1_we  input  1  1 = write, 0 = read.
REQ-009 p0_addr / p1_addr  input  ADDR_WIDTH  word address.
REQ-010 p0_wdata / p1_wdata  input  DATA_WIDTH  write data.
REQ-011 p0_wmask / p1_wmask  input  DATA_WIDTH  per-bit write enable.
REQ-012 p0_rvalid / p1_rvalid  output  1  read data valid pulse, no backpressure.
REQ-013 p0_rdata / p1_rdata  output  DATA_WIDTH  read data.
REQ-014 a_re, a_we  output  1  SRAM read and write strobes.
REQ-015 a_addr  output  ADDR_WIDTH; a_data_in, a_wmask  output  DATA_WIDTH  SRAM address, write data and mask.
REQ-016 a_data_out  input  DATA_WIDTH  SRAM read data, valid one cycle after a_re.

Function
REQ-017 Accept at most one operation per cycle; pN_ready = pN_valid & grant(N), combinational from valid and the priority state.
REQ-018 Default arbitration SHALL be round-robin: when both are valid, grant the requester not granted most recently; last_grant register updates only on an accepted transfer.
REQ-019 A lone valid requester SHALL be granted in the same cycle, whatever last_grant holds.
REQ-020 For a granted read: a_re=1, a_we=0, a_addr=pN_addr, a_wmask=0.
REQ-021 For a granted write: a_we=1, a_re=0, a_addr/a_data_in/a_wmask from the requester; the read and write are never combined.
REQ-022 A write with wmask=0 SHALL be accepted and consume a slot with no memory change.
REQ-023 With no grant: a_re=0, a_we=0, and all other SRAM outputs 0.
REQ-024 Read latency: pN_rvalid SHALL pulse exactly one cycle after acceptance, with pN_rdata=a_data_out; the owner is a registered 1-bit tag plus a valid flag.
REQ-025 pN_rdata SHALL be 0 whenever pN_rvalid=0; the non-owner's rvalid SHALL stay 0.
REQ-026 Back-to-back reads from alternating requesters SHALL sustain one read per cycle, with responses in acceptance order.
REQ-027 Writes SHALL produce no response pulse.
REQ-028 A read accepted the cycle after a write to the same address SHALL return the new data.

Reset
REQ-029 While rst=1: p0_ready=p1_ready=0, p0_rvalid=p1_rvalid=0, a_re=a_we=0, and last_grant=1, so p0 wins the first contention.
REQ-030 Reset asserted mid-read SHALL discard the in-flight response; no rvalid pulse follows deassertion.
REQ-031 The first grant SHALL be possible in the first rising edge after rst deasserts.

Configuration
REQ-032 Macro SRAM_ARB_FIXED_PRIORITY_EN: when defined, p0 SHALL always win contention and last_grant SHALL be absent. When undefined, round-robin per REQ-018 applies.

Verification
REQ-033 Reset, then p0 writes addr 3 data 0xA5 mask 0xFF -> next cycle p0 reads addr 3 -> p0_rvalid one cycle later with p0_rdata=0xA5, p1_rvalid=0.
REQ-034 Both valid reading addrs 1/2 for 4 cycles, no macro -> grants p0,p1,p0,p1; rvalid pulses alternate in the same order.
REQ-035 Same stimulus with SRAM_ARB_FIXED_PRIORITY_EN -> p0 granted all 4 cycles; p1_ready stays 0.
REQ-036 addr 7 holds 0x0F; p1 writes 0xF0 mask 0xF0 -> read addr 7 returns 0xFF.
REQ-037 p0 read accepted, rst pulsed the next cycle -> no p0_rvalid pulse at any point; after release, a lone p1 request is granted immediately.
REQ-038 Write with wmask=0x00 to addr 4 holding 0x3C -> ready=1, a_we=1; a subsequent read returns 0x3C.
